led_pwm_fader: RTL
==================

Name: led_pwm_fader

Overview:
Downstream consumer of the LED-pattern stage's per-LED on/off requests. Converts each request bit into a PWM drive for its LED. Each channel fades in or out with a fixed slope rather than switching hard. Contains a shared fade prescaler, a shared PWM counter and one four-state ramp FSM per channel. Sits in the sys clock domain between the pattern logic and the LED pads.

Parameters:
N_CH, 3, number of LED channels (one req/pwm pair each)
PWM_BITS, 8, width of brightness level and PWM counter; MAX = 2^PWM_BITS-1
TICK_DIV, 1024, sys_clk cycles per fade step (must be >= 2)
STEP, 1, level increment/decrement per fade tick (1..MAX)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  reset; synchronous and active-high
req  in  N_CH  per-channel on request from the pattern stage; level-sensitive
pwm  out  N_CH  registered PWM drive per channel
level  out  N_CH*PWM_BITS  packed current brightness; channel i at bits [i*PWM_BITS +: PWM_BITS]
busy  out  1  high while any channel is in RISE or FALL

Behaviour:
- Reset (sys_rst=1 at a clock edge): prescaler=0, pwm_cnt=0, every level=0, every FSM=OFF, pwm=0, busy=0. Reset overrides all other updates. It takes effect mid-fade with no completion of the current step.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is an internal 1-cycle strobe, high while prescaler==TICK_DIV-1.
  - First tick occurs TICK_DIV-1 cycles after reset deassertion.
- PWM counter: pwm_cnt increments every cycle and wraps MAX->0.
- PWM output: pwm[i] registered as (level[i] > pwm_cnt).
  - level=0 gives constant 0.
  - level=MAX gives high for MAX of every 2^PWM_BITS cycles.
  - Comparison uses pre-edge values, giving one cycle of latency.
- Per-channel FSM (states OFF, RISE, ON, FALL). Transitions are evaluated every cycle from registered state, req and level:
  - OFF: req=1 -> RISE.
  - RISE: req=0 -> FALL (reverse from current level, no restart); else level==MAX -> ON.
  - ON: req=0 -> FALL.
  - FALL: req=1 -> RISE; else level==0 -> OFF.
- Level update happens only on tick cycles and uses the registered state at the start of that cycle:
  - RISE: level = min(level+STEP, MAX).
  - FALL: level = max(level-STEP, 0).
  - OFF and ON: level held.
- Arithmetic is computed PWM_BITS+1 wide to detect overflow/underflow before saturating. No wrap-around of level is permitted.
- Simultaneous tick and req change: the level update uses the old state; the new state applies from the next cycle. At most one STEP in the old direction is applied.
- Saturation handover: after level reaches MAX (or 0), the state moves to ON (or OFF) on the following cycle. Level never exceeds MAX or goes below 0.
- A req pulse shorter than one cycle between ticks still changes state; level changes only if the state spans a tick.
- busy is combinational OR over channels of (state==RISE || state==FALL).
- Channels are independent; they share only tick and pwm_cnt.

Test Plan:
1. Reset: hold sys_rst 3 cycles with req=3'b111 -> pwm=0, level=0, busy=0 throughout. The first tick occurs TICK_DIV-1 cycles after release.
2. Fade-in (TICK_DIV=4, STEP=64): raise req[0] and hold -> level[0] steps 64,128,192,255 on successive ticks. The state reaches ON one cycle after 255. busy falls then. level[1], level[2] stay 0.
3. Abort mid-rise (same params): drop req[0] when level[0]=128 -> next ticks give 64, then 0. State becomes OFF, busy falls. No value exceeds 128 after the drop.
4. Duty check: force ON with level=MAX (PWM_BITS=8) -> pwm high exactly 255 of each 256-cycle window. With level=0 -> pwm high 0 cycles over 1024 cycles.
5. Simultaneous events: toggle req[1] 0->1 on the exact tick cycle while in FALL at level=64 -> that tick still yields level 0. The state is RISE next cycle, and the following tick gives 64 without passing through OFF.
6. Reset mid-operation: assert sys_rst while two channels are ramping -> next cycle all levels 0, all states OFF, pwm=0, busy=0. The ramp restarts cleanly after release.

Source files
------------

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-channel LED fade ramps with PWM drive.
// A shared prescaler paces the fades and a shared free-running counter sets the PWM phase.
module led_pwm_fader #(
    parameter int N_CH     = 3,
    parameter int PWM_BITS = 8,
    parameter int TICK_DIV = 1024,
    parameter int STEP     = 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [N_CH-1:0]          req,
    output logic [N_CH-1:0]          pwm,
    output logic [N_CH*PWM_BITS-1:0] level,
    output logic                     busy
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [PWM_BITS:0] MAX_W = {1'b0, MAX};
    localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS + 1)'(STEP);

    typedef enum logic [1:0] {OFF, RISE, ON, FALL} state_t;

    logic [PW-1:0]       presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic [N_CH-1:0]     ramping;

    assign tick = presc == LAST;
    assign busy = |ramping;

    always_ff @(posedge sys_clk)
        if (sys_rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t              state, state_n;
        logic [PWM_BITS-1:0] lvl, lvl_n;
        logic [PWM_BITS:0]   up, dn;
        logic                drive;

        // one spare bit exposes overflow/underflow before saturating
        assign up = {1'b0, lvl} + STEP_W;
        assign dn = {1'b0, lvl} - STEP_W;
        assign level[g*PWM_BITS +: PWM_BITS] = lvl;
        assign pwm[g] = drive;
        assign ramping[g] = state == RISE || state == FALL;

        always_comb begin
            lvl_n   = lvl;
            state_n = state;
            lvl_n   = !tick          ? lvl :
                      state == RISE  ? (up > MAX_W ? MAX : up[PWM_BITS-1:0]) :
                      state == FALL  ? (dn[PWM_BITS] ? '0 : dn[PWM_BITS-1:0]) : lvl;
            state_n = state == OFF   ? (req[g] ? RISE : OFF) :
                      state == RISE  ? (!req[g] ? FALL : lvl == MAX ? ON : RISE) :
                      state == ON    ? (!req[g] ? FALL : ON) :
                                       (req[g] ? RISE : lvl == '0 ? OFF : FALL);
        end

        always_ff @(posedge sys_clk)
            if (sys_rst) begin
                state <= OFF;
                lvl   <= '0;
                drive <= 1'b0;
            end else begin
                state <= state_n;
                lvl   <= lvl_n;
                drive <= lvl > pwm_cnt;
            end
    end
endmodule
